// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing constants and FSM state encoding for the FIFO controller
package fifo_pkg;

    localparam int DEPTH = 16;
    localparam int PTR_W = 5;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap-around pointer counter; the MSB is the lap bit
module fifo_ptr #(
    parameter int W = fifo_pkg::PTR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO flow controller with pointers/strobes/flags; FIFO_CTRL_ALMOST_EN adds almost flags
module fifo_ctrl #(
    parameter int DEPTH = fifo_pkg::DEPTH,
    parameter int PTR_W = fifo_pkg::PTR_W
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             en_write,
    output logic             en_read,
    output logic [PTR_W-1:0] ptr_in,
    output logic [PTR_W-1:0] ptr_out,
    output logic [PTR_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic             underflow
`ifdef FIFO_CTRL_ALMOST_EN
    ,
    output logic             almost_full,
    output logic             almost_empty
`endif
);

    import fifo_pkg::*;

    state_t           state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] count_nxt;
    logic             wr_acc;
    logic             rd_acc;

    // Flags come from the state register, so simultaneous requests resolve naturally.
    assign wr_acc = wr_req && !full;
    assign rd_acc = rd_req && !empty;

    always_comb begin
        count_nxt = count + PTR_W'(wr_acc) - PTR_W'(rd_acc);
    end

    fifo_ptr #(.W(PTR_W)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (wr_acc),
        .ptr   (wr_ptr)
    );

    fifo_ptr #(.W(PTR_W)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (rd_acc),
        .ptr   (rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= EMPTY;
            full      <= 1'b0;
            empty     <= 1'b1;
            en_write  <= 1'b0;
            en_read   <= 1'b0;
            ptr_in    <= '0;
            ptr_out   <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            en_write  <= wr_acc;
            en_read   <= rd_acc;
            count     <= count_nxt;
            overflow  <= overflow | (wr_req & full);
            underflow <= underflow | (rd_req & empty);
            if (wr_acc) begin
                ptr_in <= wr_ptr;
            end
            if (rd_acc) begin
                ptr_out <= rd_ptr;
            end
            case (state)
                EMPTY: begin
                    if (wr_acc) begin
                        state <= PARTIAL;
                        empty <= 1'b0;
                    end
                end
                PARTIAL: begin
                    if (wr_acc && !rd_acc && count == PTR_W'(DEPTH - 1)) begin
                        state <= FULL;
                        full  <= 1'b1;
                    end else if (rd_acc && !wr_acc && count == PTR_W'(1)) begin
                        state <= EMPTY;
                        empty <= 1'b1;
                    end
                end
                FULL: begin
                    if (rd_acc) begin
                        state <= PARTIAL;
                        full  <= 1'b0;
                    end
                end
                default: begin
                    state <= EMPTY;
                    full  <= 1'b0;
                    empty <= 1'b1;
                end
            endcase
        end
    end

`ifdef FIFO_CTRL_ALMOST_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (count_nxt >= PTR_W'(AF_LEVEL));
            almost_empty <= (count_nxt <= PTR_W'(AE_LEVEL));
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_req;
    logic       rd_req;
    logic       en_write;
    logic       en_read;
    logic [4:0] ptr_in;
    logic [4:0] ptr_out;
    logic [4:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;
`ifdef FIFO_CTRL_ALMOST_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    int checks = 0;
    int errors = 0;
    logic saw_bit4;

    always #5 clk = ~clk;

    fifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .en_write     (en_write),
        .en_read      (en_read),
        .ptr_in       (ptr_in),
        .ptr_out      (ptr_out),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .overflow     (overflow),
        .underflow    (underflow)
`ifdef FIFO_CTRL_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic w, input logic r);
        wr_req = w;
        rd_req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        wr_req = 1'b0;
        rd_req = 1'b0;
        do_reset();
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_en_write", en_write, 0);
        chk("rst_en_read", en_read, 0);
        chk("rst_ptr_in", ptr_in, 0);
        chk("rst_ptr_out", ptr_out, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_underflow", underflow, 0);
`ifdef FIFO_CTRL_ALMOST_EN
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_almost_full", almost_full, 0);
`endif

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0);
            chk("fill_en_write", en_write, 1);
            chk("fill_ptr_in", ptr_in, i);
            chk("fill_count", count, i + 1);
        end
        chk("fill_full", full, 1);
        chk("fill_empty", empty, 0);
`ifdef FIFO_CTRL_ALMOST_EN
        chk("fill_almost_full", almost_full, 1);
`endif

        step(1'b1, 1'b0);
        chk("ovf_en_write", en_write, 0);
        chk("ovf_count", count, 16);
        chk("ovf_flag", overflow, 1);
        step(1'b0, 1'b0);
        chk("ovf_sticky", overflow, 1);
        chk("ovf_ptr_in_hold", ptr_in, 15);

        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
            if (i < 16) begin
                chk("drain_en_read", en_read, 1);
                chk("drain_ptr_out", ptr_out, i);
                chk("drain_count", count, 15 - i);
            end else begin
                chk("drain_stop_en_read", en_read, 0);
                chk("drain_stop_count", count, 0);
            end
        end
        chk("drain_empty", empty, 1);
        chk("drain_underflow", underflow, 1);
        chk("drain_overflow_sticky", overflow, 1);

        do_reset();
        chk("rst2_overflow", overflow, 0);
        chk("rst2_underflow", underflow, 0);

        step(1'b1, 1'b1);
        chk("both_empty_en_write", en_write, 1);
        chk("both_empty_en_read", en_read, 0);
        chk("both_empty_count", count, 1);
        chk("both_empty_ptr_in", ptr_in, 0);
        chk("both_empty_underflow", underflow, 1);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
        chk("occ5_count", count, 5);

        saw_bit4 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b1);
            chk("both_en_write", en_write, 1);
            chk("both_en_read", en_read, 1);
            chk("both_count", count, 5);
            chk("both_ptr_in", ptr_in, (5 + i) % 32);
            chk("both_ptr_out", ptr_out, i % 32);
            chk("both_empty_flag", empty, 0);
            chk("both_full_flag", full, 0);
            if (ptr_out[4]) saw_bit4 = 1'b1;
        end
        chk("both_saw_bit4", saw_bit4, 1);

        for (int i = 0; i < 11; i++) step(1'b1, 1'b0);
        chk("refill_count", count, 16);
        chk("refill_full", full, 1);
        chk("refill_overflow_clear", overflow, 0);

        step(1'b1, 1'b1);
        chk("both_full_en_read", en_read, 1);
        chk("both_full_en_write", en_write, 0);
        chk("both_full_ptr_out", ptr_out, 8);
        chk("both_full_count", count, 15);
        chk("both_full_full", full, 0);
        chk("both_full_overflow", overflow, 1);

        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0);
        chk("pre_rst_count", count, 9);
        reset = 1'b1;
        step(1'b1, 1'b1);
        reset = 1'b0;
        chk("midrst_count", count, 0);
        chk("midrst_empty", empty, 1);
        chk("midrst_en_write", en_write, 0);
        chk("midrst_en_read", en_read, 0);
        chk("midrst_overflow", overflow, 0);
        chk("midrst_underflow", underflow, 0);
`ifdef FIFO_CTRL_ALMOST_EN
        chk("midrst_almost_empty", almost_empty, 1);
`endif

        step(1'b1, 1'b0);
        chk("post_rst_ptr_in", ptr_in, 0);
        chk("post_rst_en_write", en_write, 1);
        chk("post_rst_count", count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
